apb_sdcard_rdbuf: RTL
=====================

# apb_sdcard_rdbuf

APB3 read-back peripheral that receives the byte stream produced by the SD-card sector reader (the engine driven by the `sdcard_rd_en` / `sdcard_rd_addr` / `sdcard_rd_reset` controls). It packs bytes into 32-bit words, buffers one 512-byte sector in a word FIFO, and lets the CPU poll status and pop sector data over APB. It sits on the same APB subsystem as the SD-card control block, in the PCLK domain.

## Interface
- `DEPTH_LOG2`, default 7: log2 of the FIFO depth in 32-bit words; 128 words holds one sector.
- `PCLK`, in, 1: sole clock; all logic is rising-edge.
- `PRESETn`, in, 1: asynchronous active-low reset.
- `PSEL`, in, 1: APB device select.
- `PADDR`, in, [11:2]: APB word address.
- `PENABLE`, in, 1: APB access phase.
- `PWRITE`, in, 1: APB write (1) or read (0).
- `PWDATA`, in, 32: APB write data.
- `PRDATA`, out, 32: APB read data.
- `PREADY`, out, 1: tied to 1; no wait states.
- `PSLVERR`, out, 1: tied to 0.
- `sd_byte_valid`, in, 1: one-cycle qualifier for `sd_byte`.
- `sd_byte`, in, 8: sector data byte from the reader.
- `sd_sector_done`, in, 1: one-cycle pulse after the last byte of a sector.
- `sd_clear`, in, 1: synchronous flush, same effect as a CTRL write; connect it to `sdcard_rd_reset`.

## Operation
- Register map, decoded on `PADDR[3:2]`:
  - 0x00 STATUS (RO):
    - bit0 `ready`: sector done and FIFO non-empty.
    - bit1 `overflow`: sticky.
    - bit2 `underflow`: sticky.
    - bit3 `empty`.
    - bit4 `full`.
    - bits[15:8] `count`: words held, 0..128.
    - All other bits read 0.
  - 0x04 DATA (RO, destructive): returns the FIFO head; the access pops it.
  - 0x08 CTRL (WO): writing bit0=1 flushes the block.
  - Any other offset reads 0; writes to it are ignored.
- Read pop happens on `PSEL & PENABLE & ~PWRITE` at DATA.
  - `PRDATA` is combinational from the head entry.
  - The pointer advances at the end of the access phase.
- Byte packing, little-endian:
  - The first byte of each group lands in [7:0], the fourth in [31:24].
  - A 2-bit lane counter and a 24-bit partial register hold the bytes in progress.
  - The 4th byte pushes the word into the FIFO in the same cycle.
- `sd_sector_done` behaviour:
  - If the lane counter is non-zero, the partial word is zero-padded in the upper lanes and pushed.
  - The lane counter returns to 0.
  - `sector_done` is set.
  - `ready = sector_done & ~empty`.
  - `sector_done` clears when the FIFO becomes empty through pops.
- Flush (CTRL bit0=1 or `sd_clear`) clears all of the following in one cycle:
  - pointers and `count`
  - lane counter
  - `sector_done`
  - `overflow` and `underflow`
- FIFO: `DEPTH_LOG2`-bit wrap-around read and write pointers, plus a (`DEPTH_LOG2`+1)-bit count.
- Boundary conditions:
  - Push while full: the word is dropped and `overflow` is set. The lane counter still resets.
  - Pop while empty: `PRDATA` = 0, pointers and count unchanged, `underflow` set.
  - Push and pop in the same cycle: both take effect and the count is unchanged. This also holds when full, so no overflow is flagged.
  - Flush in the same cycle as a push or pop: flush wins and both are discarded.
  - `sd_sector_done` together with `sd_byte_valid`: the byte is packed first, then the padded word is pushed (one push total).

## Timing
- Reset values:
  - `PRDATA` = 0 (FIFO empty, STATUS = 0x0000_0008).
  - All pointers, counters and flags = 0.
  - Partial register = 0.
  - Memory contents are undefined and never visible, because an empty FIFO reads 0.
- APB accesses complete in the access phase; there are no wait states.
- Latency:
  - The 4th byte at cycle N becomes visible in `count` and `empty` from cycle N+1.
  - `sd_sector_done` at N makes `ready` visible from N+1.
  - A pop at N updates the head and `count` from N+1, so back-to-back APB reads return consecutive words.
- Flags set at N are readable from N+1.
- Reset asserted mid-sector or mid-access discards everything immediately.

## Test plan
- Reset, then read STATUS -> 0x0000_0008. Read DATA -> 0, and STATUS bit2 becomes 1.
- Stream bytes 0x00..0x07, then `sd_sector_done` -> STATUS `ready`=1, `count`=2. DATA reads return 0x03020100 then 0x07060504, after which `empty`=1 and `ready`=0.
- Stream bytes 0xAA, 0xBB, 0xCC, then `sd_sector_done` -> one word, 0x00CCBBAA.
- Stream 516 bytes without popping -> `count`=128, `full`=1, `overflow`=1. The first 128 words read back intact, in order.
- With the FIFO full, push and pop in the same cycle -> `count` stays 128 and `overflow` stays 0.
- Mid-sector, write CTRL 0x1, or pulse `sd_clear` with a byte in flight -> STATUS returns to 0x0000_0008. The next 4 bytes pack from lane 0.

Source files
------------

// File: rtl/apb_sdcard_rdbuf.sv
// APB3 read-back buffer for the SD-card sector reader: packs the byte stream
// little-endian into 32-bit words and holds one sector in a word FIFO for CPU polling.
module apb_sdcard_rdbuf #(
  parameter int DEPTH_LOG2 = 7
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic [11:2] PADDR,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        sd_byte_valid,
  input  logic [7:0]  sd_byte,
  input  logic        sd_sector_done,
  input  logic        sd_clear
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [1:0]            lane;
  logic [23:0]           partial;
  logic                  sector_done;
  logic                  overflow;
  logic                  underflow;

  logic        empty;
  logic        full;
  logic        ready;
  logic [1:0]  reg_sel;
  logic        rd_access;
  logic        wr_access;
  logic        flush;
  logic        pop_req;
  logic        pop_ok;
  logic        do_pop;
  logic        do_push;
  logic        ovf_set;
  logic        udf_set;
  logic [2:0]  lane_fill;
  logic [31:0] merged;
  logic [31:0] push_word;
  logic        push_req;
  logic [31:0] status;
  logic [31:0] head;
  logic        unused_apb;

  assign PREADY     = 1'b1;
  assign PSLVERR    = 1'b0;
  assign unused_apb = ^{PADDR[11:4], PWDATA[31:1]};

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);
  assign ready = sector_done & ~empty;

  assign reg_sel   = PADDR[3:2];
  assign rd_access = PSEL & PENABLE & ~PWRITE;
  assign wr_access = PSEL & PENABLE & PWRITE;
  assign flush     = sd_clear | (wr_access & (reg_sel == REG_CTRL) & PWDATA[0]);
  assign pop_req   = rd_access & (reg_sel == REG_DATA);
  assign pop_ok    = pop_req & ~empty;

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_pop  = pop_ok & ~flush;
  assign do_push = push_req & (~full | pop_ok) & ~flush;
  assign ovf_set = push_req & full & ~pop_ok & ~flush;
  assign udf_set = pop_req & empty & ~flush;

  // Merge the incoming byte into its lane, then keep only the lanes filled so far.
  always_comb begin
    lane_fill = {1'b0, lane} + {2'b00, sd_byte_valid};
    merged    = {8'h00, partial};
    if (sd_byte_valid) begin
      case (lane)
        2'd0:    merged[7:0]   = sd_byte;
        2'd1:    merged[15:8]  = sd_byte;
        2'd2:    merged[23:16] = sd_byte;
        default: merged[31:24] = sd_byte;
      endcase
    end
    push_word = '0;
    case (lane_fill)
      3'd1:    push_word[7:0]  = merged[7:0];
      3'd2:    push_word[15:0] = merged[15:0];
      3'd3:    push_word[23:0] = merged[23:0];
      3'd4:    push_word       = merged;
      default: push_word       = '0;
    endcase
    push_req = (lane_fill == 3'd4) | (sd_sector_done & (lane_fill != 3'd0));
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      lane    <= '0;
      partial <= '0;
    end else if (flush || push_req) begin
      lane    <= '0;
      partial <= '0;
    end else if (sd_byte_valid) begin
      lane    <= lane + 2'd1;
      partial <= merged[23:0];
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      sector_done <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      sector_done <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
      overflow  <= overflow | ovf_set;
      underflow <= underflow | udf_set;
      // The sector stays "ready" until the CPU drains the last word.
      if (sd_sector_done) begin
        sector_done <= 1'b1;
      end else if (do_pop && !do_push && count == COUNT_ONE) begin
        sector_done <= 1'b0;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (do_push) mem[wr_ptr] <= push_word;
  end

  assign head = mem[rd_ptr];

  always_comb begin
    status        = '0;
    status[0]     = ready;
    status[1]     = overflow;
    status[2]     = underflow;
    status[3]     = empty;
    status[4]     = full;
    status[15:8]  = 8'(count);
  end

  // An empty FIFO reads 0, so uninitialised memory never reaches the bus.
  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      case (reg_sel)
        REG_STATUS: PRDATA = status;
        REG_DATA:   PRDATA = empty ? 32'h0 : head;
        default:    PRDATA = '0;
      endcase
    end
  end

endmodule
